// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Raster timing source for a VGA output, clocked at the pixel clock. The
// horizontal/vertical counters (stage 0) are exposed as x/y so pattern
// blocks can return a colour combinationally. Stage 1 registers the syncs,
// the blanked colour and a frame-start strobe, so everything reaching the
// pins carries the same one-clock latency and stays mutually aligned.
//
// Ports:
//   clock25MHz   in   1  pixel clock, all state on the rising edge
//   reset        in   1  asynchronous, active-high reset
//   x            out 10  current horizontal count
//   y            out 10  current vertical count
//   visible      out  1  combinational, high inside the active area
//   red_in       in   4  pattern colour for the current x/y
//   green_in     in   4  pattern colour for the current x/y
//   blue_in      in   4  pattern colour for the current x/y
//   vga_hsync    out  1  registered horizontal sync
//   vga_vsync    out  1  registered vertical sync
//   vga_red      out  4  registered, blanked colour
//   vga_green    out  4  registered, blanked colour
//   vga_blue     out  4  registered, blanked colour
//   frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the pins
// ---------------------------------------------------------------------------
module vga_timing_generator #(
   parameter int unsigned H_ACTIVE        = 640,
   parameter int unsigned H_FRONT         = 16,
   parameter int unsigned H_SYNC          = 96,
   parameter int unsigned H_BACK          = 48,
   parameter int unsigned V_ACTIVE        = 480,
   parameter int unsigned V_FRONT         = 10,
   parameter int unsigned V_SYNC          = 2,
   parameter int unsigned V_BACK          = 33,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clock25MHz,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       visible,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic [3:0] vga_red,
   output logic [3:0] vga_green,
   output logic [3:0] vga_blue,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Counter-width copies of the boundaries keep every compare 10 bits wide.
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

   localparam logic       SYNC_ON    = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic       SYNC_OFF   = ~SYNC_ON;

   // Stage 0: raster counters
   logic [9:0] hcount_q, hcount_d;
   logic [9:0] vcount_q, vcount_d;

   // Stage 1: pin registers
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [3:0] red_q, red_d;
   logic [3:0] green_q, green_d;
   logic [3:0] blue_q, blue_d;
   logic       fstart_q, fstart_d;

   logic       hsync_active;
   logic       vsync_active;

   always_comb begin
      hcount_d = hcount_q + 10'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         // Last pixel of the last line: both counters wrap on the same edge.
         if (vcount_q == V_LAST) begin
            vcount_d = '0;
         end else begin
            vcount_d = vcount_q + 10'd1;
         end
      end
   end

   assign visible      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
   assign hsync_active = (hcount_q >= HS_START) && (hcount_q < HS_END);
   assign vsync_active = (vcount_q >= VS_START) && (vcount_q < VS_END);

   always_comb begin
      hsync_d  = hsync_active ? SYNC_ON : SYNC_OFF;
      vsync_d  = vsync_active ? SYNC_ON : SYNC_OFF;
      // Blanking wins over whatever the pattern block returns.
      red_d    = visible ? red_in   : 4'h0;
      green_d  = visible ? green_in : 4'h0;
      blue_d   = visible ? blue_in  : 4'h0;
      fstart_d = (hcount_q == 10'd0) && (vcount_q == 10'd0);
   end

   always_ff @(posedge clock25MHz or posedge reset) begin
      if (reset) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= SYNC_OFF;
         vsync_q  <= SYNC_OFF;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
         fstart_q <= 1'b0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
         fstart_q <= fstart_d;
      end
   end

   assign x           = hcount_q;
   assign y           = vcount_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_red     = red_q;
   assign vga_green   = green_q;
   assign vga_blue    = blue_q;
   assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// Bench for vga_timing_generator. Two instances share clock and reset:
//   big   - default 640x480 timing, colour inputs tied to 4'hF
//   small - tiny 8x4 raster (15x8 totals) with positive syncs, so whole
//           frames, wraps and a mid-frame reset fit in a short run
// Small-raster geometry: hsync h=10..12, vsync v=5..6, visible h<8 && v<4.
// Sampling is on the falling edge; n counts rising edges since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [9:0] bx, by, sx, sy;
   logic       bvis, svis;
   logic       bhs, bvs, shs, svs;
   logic [3:0] br, bg, bb, sr, sg, sb;
   logic       bfs, sfs;

   always #5 clk = ~clk;

   vga_timing_generator u_big (
      .clock25MHz (clk),
      .reset      (rst),
      .x          (bx),
      .y          (by),
      .visible    (bvis),
      .red_in     (4'hF),
      .green_in   (4'hF),
      .blue_in    (4'hF),
      .vga_hsync  (bhs),
      .vga_vsync  (bvs),
      .vga_red    (br),
      .vga_green  (bg),
      .vga_blue   (bb),
      .frame_start(bfs)
   );

   vga_timing_generator #(
      .H_ACTIVE       (8),
      .H_FRONT        (2),
      .H_SYNC         (3),
      .H_BACK         (2),
      .V_ACTIVE       (4),
      .V_FRONT        (1),
      .V_SYNC         (2),
      .V_BACK         (1),
      .SYNC_ACTIVE_LOW(1'b0)
   ) u_small (
      .clock25MHz (clk),
      .reset      (rst),
      .x          (sx),
      .y          (sy),
      .visible    (svis),
      .red_in     (4'hA),
      .green_in   (4'h5),
      .blue_in    (4'hC),
      .vga_hsync  (shs),
      .vga_vsync  (svs),
      .vga_red    (sr),
      .vga_green  (sg),
      .vga_blue   (sb),
      .frame_start(sfs)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int n;     // rising edges since release
      int x;     // expected counter after that edge
      int y;
      bit vis;
      bit hs;    // pin levels (small raster: 1 = sync active)
      bit vs;
      bit lit;   // pins carry 12'hA5C, else 0
      bit fs;
   } vec_t;

   vec_t tbl [0:18];

   initial begin
      int ti;
      int b_fs_cnt, b_hs_low, b_hs_first, b_lit0, b_lit1, b_rgb_bad, b_wrap_err, b_vs_err;
      int s_fs_cnt, s_fs_pos_err, s_lit, s_hs_cnt, s_vs_cnt, s_wrap_err;
      logic [9:0] pbx, pby, psx, psy;
      bit found;

      tbl = '{
         '{  1,  1, 0, 1, 0, 0, 1, 1},
         '{  2,  2, 0, 1, 0, 0, 1, 0},
         '{  8,  8, 0, 0, 0, 0, 1, 0},
         '{  9,  9, 0, 0, 0, 0, 0, 0},
         '{ 11, 11, 0, 0, 1, 0, 0, 0},
         '{ 13, 13, 0, 0, 1, 0, 0, 0},
         '{ 14, 14, 0, 0, 0, 0, 0, 0},
         '{ 15,  0, 1, 1, 0, 0, 0, 0},
         '{ 16,  1, 1, 1, 0, 0, 1, 0},
         '{ 60,  0, 4, 0, 0, 0, 0, 0},
         '{ 61,  1, 4, 0, 0, 0, 0, 0},
         '{ 75,  0, 5, 0, 0, 0, 0, 0},
         '{ 76,  1, 5, 0, 0, 1, 0, 0},
         '{ 86, 11, 5, 0, 1, 1, 0, 0},
         '{105,  0, 7, 0, 0, 1, 0, 0},
         '{106,  1, 7, 0, 0, 0, 0, 0},
         '{119, 14, 7, 0, 0, 0, 0, 0},
         '{120,  0, 0, 1, 0, 0, 0, 0},
         '{121,  1, 0, 1, 0, 0, 1, 1}
      };

      // Reset held for 5 clocks
      repeat (5) @(negedge clk);
      check("rst_big_hsync", 32'(bhs), 32'd1);
      check("rst_big_vsync", 32'(bvs), 32'd1);
      check("rst_big_rgb", 32'({br, bg, bb}), 32'd0);
      check("rst_big_fs", 32'(bfs), 32'd0);
      check("rst_big_xy", 32'({by, bx}), 32'd0);
      check("rst_small_sync", 32'({shs, svs}), 32'd0);
      check("rst_small_rgb", 32'({sr, sg, sb}), 32'd0);
      check("rst_small_fs", 32'(sfs), 32'd0);
      rst = 1'b0;

      ti = 0;
      b_fs_cnt = 0; b_hs_low = 0; b_hs_first = -1; b_lit0 = 0; b_lit1 = 0;
      b_rgb_bad = 0; b_wrap_err = 0; b_vs_err = 0;
      s_fs_cnt = 0; s_fs_pos_err = 0; s_lit = 0; s_hs_cnt = 0; s_vs_cnt = 0; s_wrap_err = 0;
      pbx = 10'd0; pby = 10'd0; psx = 10'd0; psy = 10'd0;

      for (int n = 1; n <= 1700; n++) begin
         @(negedge clk);

         // Small raster: table of hand-computed points
         if (ti <= 18 && tbl[ti].n == n) begin
            check($sformatf("vec%0d_x", n), 32'(sx), 32'(tbl[ti].x));
            check($sformatf("vec%0d_y", n), 32'(sy), 32'(tbl[ti].y));
            check($sformatf("vec%0d_visible", n), 32'(svis), 32'(tbl[ti].vis));
            check($sformatf("vec%0d_hsync", n), 32'(shs), 32'(tbl[ti].hs));
            check($sformatf("vec%0d_vsync", n), 32'(svs), 32'(tbl[ti].vs));
            check($sformatf("vec%0d_rgb", n), 32'({sr, sg, sb}),
                  tbl[ti].lit ? 32'h0A5C : 32'h0);
            check($sformatf("vec%0d_fs", n), 32'(sfs), 32'(tbl[ti].fs));
            ti++;
         end

         // Small raster: counter stepping and one-frame totals
         if (sx != ((psx == 10'd14) ? 10'd0 : psx + 10'd1)) s_wrap_err++;
         if (sy != ((psx != 10'd14) ? psy : (psy == 10'd7) ? 10'd0 : psy + 10'd1)) s_wrap_err++;
         if (sx > 10'd14 || sy > 10'd7) s_wrap_err++;
         psx = sx; psy = sy;
         if (sfs) begin
            s_fs_cnt++;
            if ((n - 1) % 120 != 0) s_fs_pos_err++;
         end
         if (n <= 120) begin
            if ({sr, sg, sb} == 12'hA5C) s_lit++;
            if (shs) s_hs_cnt++;
            if (svs) s_vs_cnt++;
         end

         // Big raster: first two lines on the pins
         if (bx != ((pbx == 10'd799) ? 10'd0 : pbx + 10'd1)) b_wrap_err++;
         if (by != ((pbx == 10'd799) ? pby + 10'd1 : pby)) b_wrap_err++;
         pbx = bx; pby = by;
         if (bfs) b_fs_cnt++;
         if (bvs !== 1'b1) b_vs_err++;
         if (n <= 800) begin
            if (!bhs) begin
               b_hs_low++;
               if (b_hs_first < 0) b_hs_first = n;
            end
            if ({br, bg, bb} == 12'hFFF) b_lit0++;
         end else if (n <= 1600) begin
            if ({br, bg, bb} == 12'hFFF) b_lit1++;
         end
         if ({br, bg, bb} != 12'hFFF && {br, bg, bb} != 12'h000) b_rgb_bad++;
         if (n == 1) check("big_fs_first_edge", 32'(bfs), 32'd1);
         if (n == 799) check("big_xy_799", 32'({by, bx}), {12'd0, 10'd0, 10'd799});
         if (n == 800) check("big_xy_wrap", 32'({by, bx}), {12'd0, 10'd1, 10'd0});
      end

      check("small_table_done", 32'(ti), 32'd19);
      check("small_wrap_errors", 32'(s_wrap_err), 32'd0);
      check("small_fs_count", 32'(s_fs_cnt), 32'd15);
      check("small_fs_position", 32'(s_fs_pos_err), 32'd0);
      check("small_lit_per_frame", 32'(s_lit), 32'd32);
      check("small_hsync_per_frame", 32'(s_hs_cnt), 32'd24);
      check("small_vsync_per_frame", 32'(s_vs_cnt), 32'd30);
      check("big_wrap_errors", 32'(b_wrap_err), 32'd0);
      check("big_fs_count", 32'(b_fs_cnt), 32'd1);
      check("big_vsync_idle", 32'(b_vs_err), 32'd0);
      check("big_hsync_low_len", 32'(b_hs_low), 32'd96);
      check("big_hsync_fall_edge", 32'(b_hs_first), 32'd657);
      check("big_lit_line0", 32'(b_lit0), 32'd640);
      check("big_lit_line1", 32'(b_lit1), 32'd640);
      check("big_rgb_values", 32'(b_rgb_bad), 32'd0);

      // Mid-frame asynchronous reset, asserted between edges
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (sx == 10'd5 && sy == 10'd2) found = 1'b1;
      end
      check("wait_small_5_2", 32'(found), 32'd1);
      check("pre_rst_small_rgb", 32'({sr, sg, sb}), 32'h0A5C);
      rst = 1'b1;
      #1;
      check("async_small_xy", 32'({sy, sx}), 32'd0);
      check("async_small_rgb", 32'({sr, sg, sb}), 32'd0);
      check("async_small_sync", 32'({shs, svs}), 32'd0);
      check("async_big_xy", 32'({by, bx}), 32'd0);
      check("async_big_sync", 32'({bhs, bvs}), 32'd3);
      check("async_big_rgb", 32'({br, bg, bb}), 32'd0);
      check("async_fs", 32'({bfs, sfs}), 32'd0);
      @(negedge clk);
      check("held_small_xy", 32'({sy, sx}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("restart_fs", 32'({bfs, sfs}), 32'd3);
      check("restart_small_xy", 32'({sy, sx}), 32'd1);
      check("restart_small_rgb", 32'({sr, sg, sb}), 32'h0A5C);
      check("restart_big_rgb", 32'({br, bg, bb}), 32'hFFF);
      @(negedge clk);
      check("restart_fs_drop", 32'({bfs, sfs}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
